// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8-bit UART receiver with optional even-parity check
//
// Purpose:
//   Receives 8N1 frames from an asynchronous serial line, LSB first.
//   Define UART_RX_PARITY_EN to receive 8E1 frames: this adds the PARITY state,
//   the parity_err port and even-parity checking.
//
// Parameters:
//   CLKS_PER_BIT  clkin cycles per UART bit (4..65535)
//
// Ports:
//   clkin       in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   rx          in   serial line, asynchronous to clkin, idle high
//   data_out    out  last good received byte, bit 0 = first data bit
//   data_valid  out  one-cycle pulse when data_out is updated
//   frame_err   out  one-cycle pulse when the stop bit samples low
//   busy        out  high whenever the receiver is not idle
//   parity_err  out  one-cycle pulse on parity mismatch (UART_RX_PARITY_EN only)

module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY
`endif
    } state_t;

    state_t      state_q;
    logic        rx_meta_q;
    logic        rx_sync_q;
    logic [15:0] timer_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  data_out_q;
    logic        data_valid_q;
    logic        frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic        parity_bad_q;
    logic        parity_err_q;
`endif

    logic        rxs;
    logic        half_hit_d;
    logic        full_hit_d;
    logic [15:0] timer_inc_d;

    assign rxs         = rx_sync_q;
    assign half_hit_d  = (timer_q == HALF_LAST);
    assign full_hit_d  = (timer_q == FULL_LAST);
    // Each state clears the timer on its terminal count, so this never wraps.
    assign timer_inc_d = timer_q + 16'd1;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            timer_q      <= 16'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    timer_q   <= 16'd0;
                    bit_idx_q <= 3'd0;
                    if (!rxs) begin
                        state_q <= S_START;
                    end
                end

                // Re-check the start bit at its midpoint; a high line here
                // was a glitch and is dropped silently.
                S_START: begin
                    if (half_hit_d) begin
                        timer_q <= 16'd0;
                        state_q <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        timer_q <= timer_inc_d;
                    end
                end

                S_DATA: begin
                    if (full_hit_d) begin
                        timer_q   <= 16'd0;
                        shift_q   <= {rxs, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        timer_q <= timer_inc_d;
                    end
                end

`ifdef UART_RX_PARITY_EN
                // Even parity: data bits plus parity bit must XOR to zero.
                S_PARITY: begin
                    if (full_hit_d) begin
                        timer_q      <= 16'd0;
                        parity_bad_q <= ^{shift_q, rxs};
                        state_q      <= S_STOP;
                    end else begin
                        timer_q <= timer_inc_d;
                    end
                end
`endif

                S_STOP: begin
                    if (full_hit_d) begin
                        timer_q <= 16'd0;
                        if (rxs) begin
                            // Returning to IDLE here lets a start bit that
                            // follows immediately be caught next cycle.
                            state_q <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (parity_bad_q) begin
                                parity_err_q <= 1'b1;
                            end else begin
                                data_out_q   <= shift_q;
                                data_valid_q <= 1'b1;
                            end
`else
                            data_out_q   <= shift_q;
                            data_valid_q <= 1'b1;
`endif
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end else begin
                        timer_q <= timer_inc_d;
                    end
                end

                // Held-low line after a framing error: wait for idle before
                // looking for another start bit.
                S_BREAK: begin
                    timer_q <= 16'd0;
                    if (rxs) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    timer_q <= 16'd0;
                end
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx

module tb_uart_rx;

    localparam int CPB = 16;

    logic       clkin = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int         total  = 0;
    int         bad    = 0;
    int         dv_cnt = 0;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_byte;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clkin = ~clkin;

    task automatic monitor();
        bit dv_prev;
        int pulses;
        dv_prev = 1'b0;
        forever begin
            @(negedge clkin);
            if (dv_prev) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_after_valid: got %b want 0", busy);
                end
            end
            dv_prev = (data_valid === 1'b1);
            pulses  = 0;
            if (data_valid === 1'b1) begin
                pulses++;
                dv_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid: got data_out=%02h with nothing expected", data_out);
                end else begin
                    exp_byte = exp_q.pop_front();
                    if (data_out !== exp_byte) begin
                        bad++;
                        $display("FAIL data_out: got %02h want %02h", data_out, exp_byte);
                    end
                end
            end
            if (frame_err === 1'b1) begin
                pulses++;
                fe_cnt++;
            end
`ifdef UART_RX_PARITY_EN
            if (parity_err === 1'b1) begin
                pulses++;
                pe_cnt++;
            end
`endif
            if (pulses != 0) begin
                total++;
                if (pulses > 1) begin
                    bad++;
                    $display("FAIL pulse_exclusive: got %0d pulses want 1", pulses);
                end
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_b);
`endif
        send_bit(stop_b);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_cycles(3);
        @(negedge clkin);
        total += 4;
        if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out: got %02h want 00", data_out); end
        if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
        if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(posedge clkin);
        #1;
        rst_n = 1'b1;
        wait_cycles(4);
    endtask

    task automatic test_single();
        int dv0, fe0;
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        exp_q.push_back(8'h99);
        send_frame(8'h99, 1'b1, 1'b0);
        wait_cycles(8);
        total += 4;
        if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL single_valid_count: got %0d want 1", dv_cnt - dv0); end
        if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL single_frame_err: got %0d want 0", fe_cnt - fe0); end
        if (data_out !== 8'h99) begin bad++; $display("FAIL single_data_out: got %02h want 99", data_out); end
        if (busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", busy); end
    endtask

    task automatic test_glitch();
        int  dv0, fe0;
        bit  seen_busy;
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        seen_busy = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clkin);
            #1;
            if (i == 3) rx = 1'b1;
            @(negedge clkin);
            if (busy === 1'b1) seen_busy = 1'b1;
        end
        wait_cycles(30);
        total += 4;
        if (seen_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_seen: got %b want 1", seen_busy); end
        if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
        if (dv_cnt - dv0 !== 0) begin bad++; $display("FAIL glitch_valid: got %0d want 0", dv_cnt - dv0); end
        if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL glitch_frame_err: got %0d want 0", fe_cnt - fe0); end
    endtask

    task automatic test_frame_err();
        int         dv0, fe0, busy_low;
        logic [7:0] prev;
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        prev = 8'h99;
        busy_low = 0;
        send_frame(8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            @(negedge clkin);
            if (busy !== 1'b1) busy_low++;
        end
        @(posedge clkin);
        #1;
        total += 2;
        if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", fe_cnt - fe0); end
        if (busy_low !== 0) begin bad++; $display("FAIL ferr_busy_held: got %0d low cycles want 0", busy_low); end
        rx = 1'b1;
        wait_cycles(5);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy_release: got %b want 0", busy); end
        wait_cycles(30);
        total += 3;
        if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL ferr_no_more: got %0d want 1", fe_cnt - fe0); end
        if (dv_cnt - dv0 !== 0) begin bad++; $display("FAIL ferr_valid: got %0d want 0", dv_cnt - dv0); end
        if (data_out !== prev) begin bad++; $display("FAIL ferr_data_out: got %02h want %02h", data_out, prev); end
    endtask

    task automatic test_back_to_back();
        int dv0;
        dv0 = dv_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        wait_cycles(10);
        total += 2;
        if (dv_cnt - dv0 !== 2) begin bad++; $display("FAIL b2b_valid_count: got %0d want 2", dv_cnt - dv0); end
        if (data_out !== 8'hFF) begin bad++; $display("FAIL b2b_data_out: got %02h want ff", data_out); end
    endtask

    task automatic test_reset_mid();
        int         dv0;
        logic [7:0] a5;
        a5 = 8'hA5;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(a5[i]);
        rx = a5[3];
        wait_cycles(8);
        rst_n = 1'b0;
        #1;
        total += 4;
        if (data_out !== 8'h00) begin bad++; $display("FAIL rstmid_data_out: got %02h want 00", data_out); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (data_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", data_valid); end
        if (frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_frame_err: got %b want 0", frame_err); end
        wait_cycles(3);
        rx = 1'b1;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(5);
        dv0 = dv_cnt;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle: got %b want 0", busy); end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_cycles(8);
        total += 2;
        if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL rstmid_next_count: got %0d want 1", dv_cnt - dv0); end
        if (data_out !== 8'h3C) begin bad++; $display("FAIL rstmid_next_data: got %02h want 3c", data_out); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int dv0, pe0;
        dv0 = dv_cnt;
        pe0 = pe_cnt;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_cycles(8);
        total += 3;
        if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL par_good_valid: got %0d want 1", dv_cnt - dv0); end
        if (pe_cnt - pe0 !== 0) begin bad++; $display("FAIL par_good_err: got %0d want 0", pe_cnt - pe0); end
        if (data_out !== 8'h07) begin bad++; $display("FAIL par_good_data: got %02h want 07", data_out); end
        send_frame(8'h07, 1'b1, 1'b0);
        wait_cycles(8);
        total += 3;
        if (pe_cnt - pe0 !== 1) begin bad++; $display("FAIL par_bad_err: got %0d want 1", pe_cnt - pe0); end
        if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL par_bad_valid: got %0d want 1", dv_cnt - dv0); end
        if (data_out !== 8'h07) begin bad++; $display("FAIL par_bad_data: got %02h want 07", data_out); end
    endtask
`endif

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        wait_cycles(4);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clkin cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have port clkin  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx  input  1  serial line, asynchronous to clkin, idle high.
REQ-005 SHALL have port data_out  output  8  last good received byte, bit 0 = first data bit on the line.
REQ-006 SHALL have port data_valid  output  1  one-cycle pulse when data_out is updated.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse when a stop bit samples low.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port parity_err  output  1  one-cycle pulse on parity mismatch; present only with UART_RX_PARITY_EN.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rxs.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP, BREAK, plus a 16-bit bit-timer and a 3-bit bit index.
REQ-012 IDLE: on rxs=0, go to START and clear the timer.
REQ-013 START: at timer = CLKS_PER_BIT/2-1 (integer division), sample rxs; 0 -> DATA with timer cleared; 1 -> IDLE with no flag (glitch rejection).
REQ-014 DATA: at timer = CLKS_PER_BIT-1, sample rxs into the shift register LSB-first and clear the timer; after the 8th sample (index 7), go to STOP, or to PARITY with the macro.
REQ-015 PARITY: at timer = CLKS_PER_BIT-1, sample the parity bit and go to STOP; even parity over 8 data bits plus the parity bit is expected.
REQ-016 STOP: at timer = CLKS_PER_BIT-1, sample rxs.
REQ-017 On a STOP sample of 1: load data_out, pulse data_valid for 1 cycle, and go to IDLE in the same cycle.
REQ-018 On a STOP sample of 0: pulse frame_err, leave data_out unchanged, and go to BREAK.
REQ-019 BREAK: stay until rxs=1, then go to IDLE; a low line is never treated as a new start bit.
REQ-020 With the macro, a parity mismatch SHALL pulse parity_err in the same cycle as the STOP-sample response, and SHALL suppress data_valid and the data_out update.
REQ-021 A start bit arriving in the cycle that leaves STOP SHALL be detected on the next IDLE cycle, so back-to-back frames with one stop bit are received without loss.
REQ-022 Pulses (data_valid, frame_err, parity_err) SHALL be mutually exclusive and registered.
REQ-023 Timer increments SHALL never exceed CLKS_PER_BIT-1; there is no wrap-around path.

Reset
REQ-024 On rst_n=0, the block SHALL asynchronously force: state IDLE, timer 0, index 0, shift register 0, data_out 8'h00, data_valid 0, frame_err 0, parity_err 0, busy 0, synchronizer flops 1.
REQ-025 Reset asserted mid-frame SHALL discard the partial byte with no pulse; after release, reception resumes only on a fresh falling edge seen in IDLE.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: the PARITY state, the parity_err port, and even-parity checking SHALL be compiled in; frame = start + 8 data + parity + stop.
REQ-027 Macro UART_RX_PARITY_EN undefined: there SHALL be no PARITY state and no parity_err port; frame = start + 8 data + stop (8N1).

Verification
REQ-028 Test with CLKS_PER_BIT=16, macro off. Send 8N1 byte 0x99 -> exactly one data_valid, data_out=0x99, busy low again 1 cycle later, frame_err never high.
REQ-029 Drive rx low for 4 cycles, then high -> busy high briefly, return to IDLE, no data_valid or frame_err.
REQ-030 Send 0x55 with stop bit forced 0, then hold rx low 64 cycles -> one frame_err pulse, data_out unchanged, busy held high until rx rises, no further pulses.
REQ-031 Send 0x00 and 0xFF back-to-back with a single stop bit -> two data_valid pulses, data_out 0x00 then 0xFF.
REQ-032 Assert rst_n low during data bit 3 of 0xA5 -> outputs at reset values immediately; a following 0x3C is received correctly.
REQ-033 Macro on: send 0x07 with parity 1 -> data_valid and data_out=0x07; send 0x07 with parity 0 -> parity_err pulse, no data_valid, data_out stays 0x07.
